// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I front end.
// Contents:
//   XLEN          - datapath width
//   NOP           - canonical bubble instruction (addi x0, x0, 0)
//   fetch_state_e - fetch FSM state encoding
//   pc_plus4      - 32-bit modulo PC increment used by fetch and IF/ID
package rv32i_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,  // drive a request for PC_f
    WAIT  = 2'd1,  // one request outstanding
    HOLD  = 2'd2,  // response captured while fetch was stalled
    KILL  = 2'd3   // outstanding request belongs to a redirected-away path
  } fetch_state_e;

  // Wraps naturally: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and memory.
// Signals:
//   imem_req    - single-cycle request strobe (fetch -> memory)
//   imem_addr   - request address            (fetch -> memory)
//   imem_rvalid - response strobe            (memory -> fetch)
//   imem_rdata  - response instruction       (memory -> fetch)
// Modports: master = fetch side, slave = memory side.
interface fetch_stage_if;
  import rv32i_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register.
// Priority: flush > stall > load; with none of them the register takes a bubble.
// Ports:
//   clk, rst           - clock and synchronous active-high reset
//   stall, flush       - hazard-unit hold / bubble controls
//   load               - a fetch completes this cycle
//   instr, pc          - the completing fetch
//   instr_d, pc_d, pcplus4_d, valid_d - register contents
module if_id_reg
  import rv32i_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [XLEN-1:0] instr,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr_d,
  output logic [XLEN-1:0] pc_d,
  output logic [XLEN-1:0] pcplus4_d,
  output logic            valid_d
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_d   <= NOP;
      pc_d      <= '0;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (flush) begin
      // PC fields are left alone: they are meaningless while valid_d is low.
      instr_d <= NOP;
      valid_d <= 1'b0;
    end else if (stall) begin
      instr_d   <= instr_d;
      pc_d      <= pc_d;
      pcplus4_d <= pcplus4_d;
      valid_d   <= valid_d;
    end else if (load) begin
      instr_d   <= instr;
      pc_d      <= pc;
      pcplus4_d <= pc_plus4(pc);
      valid_d   <= 1'b1;
    end else begin
      instr_d <= NOP;
      valid_d <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with a single-outstanding-request memory port.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   Stall_f      - hold the fetch PC (responses are parked in the hold buffer)
//   Stall_d      - hold the IF/ID register
//   Flush_d      - bubble into the IF/ID register
//   PCSrc_e      - redirect from execute, target on PCTarget_e
//   imem         - instruction memory bus (master side)
//   Instr_d, PC_d, PCPlus4_d, Valid_d - IF/ID register contents
// The hazard unit is expected to raise Stall_f whenever it raises Stall_d,
// otherwise a fetch completing under Stall_d alone would be lost.
module fetch_stage
  import rv32i_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Stall_f,
  input  logic             Stall_d,
  input  logic             Flush_d,
  input  logic             PCSrc_e,
  input  logic [XLEN-1:0]  PCTarget_e,
  fetch_stage_if.master    imem,
  output logic [XLEN-1:0]  Instr_d,
  output logic [XLEN-1:0]  PC_d,
  output logic [XLEN-1:0]  PCPlus4_d,
  output logic             Valid_d
);

  fetch_state_e    state_reg;
  logic [XLEN-1:0] pc_f_reg;
  logic [XLEN-1:0] hold_reg;

  logic [XLEN-1:0] pc_f_plus4;
  logic            req;
  logic [XLEN-1:0] addr;
  logic            fetch_done;
  logic [XLEN-1:0] fetch_instr;

  assign pc_f_plus4 = pc_plus4(pc_f_reg);

  // Request and completion depend on this cycle's response and redirect so
  // that a 1-cycle memory sustains one instruction per cycle.
  always_comb begin
    req         = 1'b0;
    addr        = pc_f_reg;
    fetch_done  = 1'b0;
    fetch_instr = imem.imem_rdata;
    if (!rst) begin
      case (state_reg)
        ISSUE: begin
          // Any response seen here belongs to an abandoned request.
          req = ~PCSrc_e;
        end
        WAIT: begin
          if (imem.imem_rvalid && !PCSrc_e && !Stall_f) begin
            fetch_done = 1'b1;
            req        = 1'b1;
            addr       = pc_f_plus4;
          end
        end
        HOLD: begin
          if (!PCSrc_e && !Stall_f) begin
            fetch_done  = 1'b1;
            fetch_instr = hold_reg;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ISSUE;
      pc_f_reg  <= RESET_PC;
      hold_reg  <= '0;
    end else begin
      case (state_reg)
        ISSUE: begin
          if (PCSrc_e) begin
            pc_f_reg <= PCTarget_e;
          end else begin
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (PCSrc_e) begin
            pc_f_reg <= PCTarget_e;
            // Without the response yet, it must be swallowed when it arrives.
            state_reg <= imem.imem_rvalid ? ISSUE : KILL;
          end else if (imem.imem_rvalid) begin
            if (Stall_f) begin
              hold_reg  <= imem.imem_rdata;
              state_reg <= HOLD;
            end else begin
              pc_f_reg <= pc_f_plus4;
            end
          end
        end
        HOLD: begin
          if (PCSrc_e) begin
            pc_f_reg  <= PCTarget_e;
            hold_reg  <= '0;
            state_reg <= ISSUE;
          end else if (!Stall_f) begin
            pc_f_reg  <= pc_f_plus4;
            state_reg <= ISSUE;
          end
        end
        KILL: begin
          if (PCSrc_e) begin
            pc_f_reg <= PCTarget_e;
          end
          if (imem.imem_rvalid) begin
            state_reg <= ISSUE;
          end
        end
        default: begin
          state_reg <= ISSUE;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk       (clk),
    .rst       (rst),
    .stall     (Stall_d),
    .flush     (Flush_d),
    .load      (fetch_done),
    .instr     (fetch_instr),
    .pc        (pc_f_reg),
    .instr_d   (Instr_d),
    .pc_d      (PC_d),
    .pcplus4_d (PCPlus4_d),
    .valid_d   (Valid_d)
  );

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP_I = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        pcsrc_e;
  logic [31:0] pctarget_e;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .Stall_f    (stall_f),
    .Stall_d    (stall_d),
    .Flush_d    (flush_d),
    .PCSrc_e    (pcsrc_e),
    .PCTarget_e (pctarget_e),
    .imem       (bus),
    .Instr_d    (instr_d),
    .PC_d       (pc_d),
    .PCPlus4_d  (pcplus4_d),
    .Valid_d    (valid_d)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard: expected request addresses and expected delivered PCs.
  logic [31:0] addr_q[$];
  logic [31:0] exp_pc_q[$];
  int          valid_cyc[$];

  // Memory model: one pending response, delivered mem_delay cycles after req.
  int          mem_delay = 1;
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  bit          outstanding = 0;

  bit          started = 0;
  bit          prev_rst = 0;
  bit          prev_sd = 0;
  bit          prev_fd = 0;
  bit          held_valid = 0;
  logic [31:0] held_pc = '0;
  int          cyc = 0;
  int          t0 = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Checks IF/ID contents produced by the previous clock edge.
  task automatic check_ifid();
    if (!started) return;
    if (prev_rst) begin
      chk("rst_valid", {31'b0, valid_d}, 32'd0);
      chk("rst_instr", instr_d, NOP_I);
      chk("rst_pc", pc_d, 32'd0);
      chk("rst_pcplus4", pcplus4_d, 32'd0);
      held_valid = 0;
    end else if (prev_fd) begin
      chk("flush_valid", {31'b0, valid_d}, 32'd0);
      chk("flush_instr", instr_d, NOP_I);
      held_valid = 0;
    end else if (prev_sd) begin
      chk("stall_valid", {31'b0, valid_d}, {31'b0, held_valid});
      if (held_valid) begin
        chk("stall_pc", pc_d, held_pc);
        chk("stall_instr", instr_d, mem_word(held_pc));
      end
    end else if (valid_d === 1'b1) begin
      if (exp_pc_q.size() == 0) begin
        chk("valid_unexpected", {31'b0, valid_d}, 32'd0);
      end else begin
        held_pc    = exp_pc_q.pop_front();
        held_valid = 1;
        chk("pc_d", pc_d, held_pc);
        chk("instr_d", instr_d, mem_word(held_pc));
        chk("pcplus4_d", pcplus4_d, held_pc + 32'd4);
        valid_cyc.push_back(cyc);
        $display("cycle %0d: delivered pc=%h instr=%h", cyc, pc_d, instr_d);
      end
    end else begin
      chk("bubble_valid", {31'b0, valid_d}, 32'd0);
      chk("bubble_instr", instr_d, NOP_I);
      held_valid = 0;
    end
  endtask

  // One clock cycle, entered and left just after the falling edge.
  task automatic cycle(input logic r, input logic sf, input logic sd, input logic fd,
                       input logic ps, input logic [31:0] tgt);
    check_ifid();
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = $urandom;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(pend_addr);
        pend            = 0;
        outstanding     = 0;
      end
    end
    rst        = r;
    stall_f    = sf;
    stall_d    = sd;
    flush_d    = fd;
    pcsrc_e    = ps;
    pctarget_e = tgt;
    #1;
    if (r) begin
      chk("req_in_reset", {31'b0, bus.imem_req}, 32'd0);
    end else if (bus.imem_req === 1'b1) begin
      chk("single_outstanding", {31'b0, outstanding}, 32'd0);
      if (addr_q.size() == 0) chk("req_unexpected", {31'b0, bus.imem_req}, 32'd0);
      else chk("imem_addr", bus.imem_addr, addr_q.pop_front());
      $display("cycle %0d: request addr=%h", cyc, bus.imem_addr);
      pend        = 1;
      pend_cnt    = mem_delay;
      pend_addr   = bus.imem_addr;
      outstanding = 1;
    end
    // Reset abandons the outstanding request; its response may still arrive.
    if (r) outstanding = 0;
    prev_rst = r;
    prev_sd  = sd;
    prev_fd  = fd;
    started  = 1;
    cyc++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  // Two reset cycles, leftover-scoreboard check, then set up the next scenario.
  task automatic reset_phase(input int d);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    chk("addr_q_left", 32'(addr_q.size()), 32'd0);
    chk("exp_q_left", 32'(exp_pc_q.size()), 32'd0);
    addr_q.delete();
    exp_pc_q.delete();
    valid_cyc.delete();
    mem_delay = d;
    t0 = cyc;
  endtask

  task automatic check_spacing(input string tag, input int n, input int first, input int gap);
    chk({tag, "_count"}, 32'(valid_cyc.size()), 32'(n));
    if (valid_cyc.size() == n) begin
      chk({tag, "_first"}, 32'(valid_cyc[0]), 32'(t0 + first));
      for (int i = 1; i < n; i++) chk({tag, "_gap"}, 32'(valid_cyc[i] - valid_cyc[i-1]), 32'(gap));
    end
  endtask

  initial begin
    rst = 1'b1; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    pcsrc_e = 1'b0; pctarget_e = '0;
    bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    @(negedge clk);

    // Back-to-back stream with a 1-cycle memory.
    reset_phase(1);
    for (int i = 0; i < 6; i++) addr_q.push_back(32'(4 * i));
    for (int i = 0; i < 5; i++) exp_pc_q.push_back(32'(4 * i));
    run(6);
    check_spacing("stream", 4, 2, 1);

    // Slow memory: three dead cycles between request and response.
    reset_phase(4);
    for (int i = 0; i < 4; i++) addr_q.push_back(32'(4 * i));
    for (int i = 0; i < 3; i++) exp_pc_q.push_back(32'(4 * i));
    run(14);
    check_spacing("slow", 3, 5, 4);

    // Stall while the response for PC 8 returns; no refetch of 8 afterwards.
    reset_phase(1);
    for (int i = 0; i < 6; i++) addr_q.push_back(32'(4 * i));
    for (int i = 0; i < 5; i++) exp_pc_q.push_back(32'(4 * i));
    run(3);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
    run(4);
    chk("stall_count", 32'(valid_cyc.size()), 32'd4);

    // Redirect while the request for PC 12 is outstanding.
    reset_phase(2);
    addr_q = '{32'd0, 32'd4, 32'd8, 32'd12, 32'h100, 32'h104};
    exp_pc_q = '{32'd0, 32'd4, 32'd8, 32'h100};
    run(7);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    run(5);
    chk("redirect_count", 32'(valid_cyc.size()), 32'd4);
    if (valid_cyc.size() == 4) chk("redirect_when", 32'(valid_cyc[3]), 32'(t0 + 12));

    // Flush coinciding with a completing fetch drops that instruction.
    reset_phase(1);
    for (int i = 0; i < 5; i++) addr_q.push_back(32'(4 * i));
    exp_pc_q = '{32'd0, 32'd8, 32'd12};
    run(2);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
    run(2);

    // Redirect in ISSUE to the top of the address space; PC wraps to 0.
    reset_phase(1);
    addr_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd0, 32'd4};
    exp_pc_q = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'd0};
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    run(4);

    // Reset mid-WAIT; the late response lands in ISSUE and must be ignored.
    reset_phase(3);
    addr_q = '{32'd0, 32'd4, 32'd8, 32'd0, 32'd4};
    exp_pc_q = '{32'd0, 32'd4, 32'd0};
    run(7);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    run(5);
    chk("late_rsp_count", 32'(valid_cyc.size()), 32'd3);
    if (valid_cyc.size() == 3) chk("late_rsp_when", 32'(valid_cyc[2]), 32'(t0 + 13));

    reset_phase(1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, giving the PC fetched first after reset.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port Stall_f  input  1  hazard-unit hold of the fetch PC.
REQ-005 SHALL have port Stall_d  input  1  hazard-unit hold of the IF/ID register.
REQ-006 SHALL have port Flush_d  input  1  hazard-unit bubble into the IF/ID register.
REQ-007 SHALL have port PCSrc_e  input  1  taken branch or jump redirect from execute.
REQ-008 SHALL have port PCTarget_e  input  32  redirect target.
REQ-009 SHALL have port imem_req  output  1  single-cycle instruction-memory request strobe.
REQ-010 SHALL have port imem_addr  output  32  request address.
REQ-011 SHALL have port imem_rvalid  input  1  response strobe.
REQ-012 SHALL have port imem_rdata  input  32  response instruction.
REQ-013 SHALL have ports Instr_d / PC_d / PCPlus4_d  output  32 each  IF/ID register contents.
REQ-014 SHALL have port Valid_d  output  1  high when Instr_d is a real fetched instruction.

Function
REQ-015 The memory SHALL see at most one outstanding request, and each request SHALL receive exactly one response, at least 1 cycle later.
REQ-016 The FSM SHALL have the states ISSUE, WAIT, HOLD and KILL.
REQ-017 In ISSUE: imem_req=~PCSrc_e and imem_addr=PC_f; if PCSrc_e is high, the stage SHALL set PC_f<=PCTarget_e and stay in ISSUE, otherwise it SHALL go to WAIT.
REQ-018 In WAIT with imem_rvalid=1, PCSrc_e=0 and Stall_f=0: the fetch completes, PC_f<=PC_f+4, the same cycle issues imem_req=1 with imem_addr=PC_f+4, and the state stays WAIT (sustains 1 instr/cycle at 1-cycle latency).
REQ-019 In WAIT with imem_rvalid=1, PCSrc_e=0 and Stall_f=1: imem_rdata SHALL be captured into the hold buffer and the state goes to HOLD.
REQ-020 In HOLD with Stall_f=0: the buffered fetch completes, PC_f<=PC_f+4, and the state goes to ISSUE.
REQ-021 Redirect (PCSrc_e=1) handling: PC_f<=PCTarget_e always, and no fetch completes that cycle.
 - WAIT without imem_rvalid -> KILL.
 - WAIT with imem_rvalid -> response discarded, -> ISSUE.
 - HOLD -> buffer dropped, -> ISSUE.
REQ-022 In KILL: imem_rvalid SHALL be discarded and the state goes to ISSUE; a further PCSrc_e updates PC_f and the state stays KILL.
REQ-023 IF/ID register priority: Flush_d > Stall_d > load.
 - Flush_d: Valid_d=0, Instr_d=NOP (32'h0000_0013).
 - Stall_d: hold all of Instr_d, PC_d, PCPlus4_d and Valid_d.
 - Fetch completing: Instr_d=data, PC_d=fetched PC, PCPlus4_d=PC+4, Valid_d=1.
 - Otherwise: bubble (Valid_d=0, Instr_d=NOP).
REQ-024 PC arithmetic SHALL be 32-bit modulo: 32'hFFFF_FFFC+4 = 32'h0000_0000.

Reset
REQ-025 rst SHALL force state=ISSUE, PC_f=RESET_PC, Instr_d=NOP, PC_d=0, PCPlus4_d=0, Valid_d=0, hold buffer cleared; imem_req=0 during the reset cycle.
REQ-026 A reset asserted while a request is outstanding SHALL abandon that request, and the stage SHALL ignore any imem_rvalid arriving in ISSUE.

Structure
REQ-027 The FSM state enum and the NOP constant SHALL live in shared package rv32i_pkg.
REQ-028 The IF/ID register SHALL be one sub-module, if_id_reg, implementing REQ-023; the FSM and PC logic stay in fetch_stage.

Verification
REQ-029 Reset, 1-cycle memory, no stalls -> imem_addr 0,4,8 on consecutive cycles; Valid_d=1 with PC_d 0,4,8 back-to-back.
REQ-030 3-cycle memory latency -> one instruction every 4 cycles; Valid_d=0 bubbles in between; never two outstanding requests.
REQ-031 Stall_f=Stall_d=1 for 3 cycles while the response for PC 8 returns -> Instr_d holds PC 4; after release Instr_d = PC 8 data, with no refetch of 8.
REQ-032 PCSrc_e=1 with PCTarget_e=32'h100 while the request for PC 12 is outstanding in WAIT -> stale response dropped; next Valid_d=1 has PC_d=32'h100.
REQ-033 Flush_d together with a completing fetch -> Valid_d=0, Instr_d=32'h0000_0013.
REQ-034 rst asserted mid-WAIT, late imem_rvalid in ISSUE -> response ignored; first delivered PC_d=RESET_PC.
